// File: rtl/podule_bus_ctrl.sv
// Podule expansion-slot bus controller: decodes the slot from the IOC podule address,
// inserts cycle-speed wait states, runs the slot ack handshake with timeout, merges interrupts.
module podule_bus_ctrl #(
    parameter int unsigned NUM_SLOTS = 4,
    parameter logic [3:0]  SLOT_MASK = 4'b0001,
    parameter int unsigned SLOW_WS   = 15,
    parameter int unsigned MED_WS    = 7,
    parameter int unsigned FAST_WS   = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                    clkcpu,
    input  logic                    rst_i,
    input  logic                    clk2m_en,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [1:0]              wb_speed,
    input  logic [13:0]             wb_adr,
    input  logic [15:0]             wb_dat_i,
    output logic [15:0]             wb_dat_o,
    output logic                    wb_ack,
    output logic                    timeout_o,
    output logic [NUM_SLOTS-1:0]    pod_sel,
    output logic                    pod_we,
    output logic [11:0]             pod_adr,
    output logic [15:0]             pod_wdat,
    input  logic [16*NUM_SLOTS-1:0] pod_rdat,
    input  logic [NUM_SLOTS-1:0]    pod_ack,
    input  logic [NUM_SLOTS-1:0]    pod_irq,
    input  logic [NUM_SLOTS-1:0]    pod_firq,
    output logic                    irq_o,
    output logic                    firq_o
);

    // Slots that both exist and are populated; everything else completes with 16'hFFFF.
    localparam logic [3:0] SlotRange = 4'((5'd1 << NUM_SLOTS) - 5'd1);
    localparam logic [3:0] SlotOk    = SLOT_MASK & SlotRange;
    localparam logic [7:0] ToLast    = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StStrobe, StAck} state_e;

    state_e      state_q;
    logic [1:0]  slot_q;
    logic        we_q;
    logic        sync_q;
    logic [7:0]  wcnt_q;
    logic [7:0]  tcnt_q;
    logic [3:0]  sel_q;
    logic        pod_we_q;
    logic [11:0] pod_adr_q;
    logic [15:0] pod_wdat_q;
    logic [15:0] rdat_q;
    logic        wb_ack_q;
    logic        timeout_q;
    logic        irq_q;
    logic        firq_q;

    logic [7:0]  ws_load;
    logic        req;
    logic        req_ok;
    logic [3:0]  req_onehot;
    logic        cur_ok;
    logic [3:0]  cur_onehot;
    logic [3:0]  ack_ext;
    logic [15:0] rdat_slot [4];

    for (genvar i = 0; i < 4; i++) begin : g_rdat
        if (i < NUM_SLOTS) begin : g_pop
            assign rdat_slot[i] = pod_rdat[16*i +: 16];
        end else begin : g_nopop
            assign rdat_slot[i] = 16'h0000;
        end
    end

    assign ack_ext    = 4'(pod_ack);
    assign req        = wb_cyc && wb_stb;
    assign req_ok     = SlotOk[wb_adr[13:12]];
    assign req_onehot = 4'b0001 << wb_adr[13:12];
    assign cur_ok     = SlotOk[slot_q];
    assign cur_onehot = 4'b0001 << slot_q;

    always_comb begin
        ws_load = 8'd0;
        unique case (wb_speed)
            2'b00:   ws_load = 8'(SLOW_WS);
            2'b01:   ws_load = 8'(MED_WS);
            2'b10:   ws_load = 8'(FAST_WS);
            default: ws_load = 8'd0;
        endcase
    end

    always_ff @(posedge clkcpu) begin
        if (rst_i) begin
            state_q    <= StIdle;
            slot_q     <= 2'd0;
            we_q       <= 1'b0;
            sync_q     <= 1'b0;
            wcnt_q     <= 8'd0;
            tcnt_q     <= 8'd0;
            sel_q      <= 4'd0;
            pod_we_q   <= 1'b0;
            pod_adr_q  <= 12'd0;
            pod_wdat_q <= 16'd0;
            rdat_q     <= 16'd0;
            wb_ack_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            wb_ack_q  <= 1'b0;
            timeout_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        slot_q     <= wb_adr[13:12];
                        we_q       <= wb_we;
                        pod_adr_q  <= wb_adr[11:0];
                        pod_wdat_q <= wb_dat_i;
                        sync_q     <= (wb_speed == 2'b11);
                        wcnt_q     <= ws_load;
                        tcnt_q     <= 8'd0;
                        if (wb_speed != 2'b11 && ws_load == 8'd0) begin
                            state_q  <= StStrobe;
                            sel_q    <= req_ok ? req_onehot : 4'd0;
                            pod_we_q <= req_ok && wb_we;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (!req) begin
                        state_q <= StIdle;
                    end else if (sync_q ? clk2m_en : (wcnt_q == 8'd1)) begin
                        // Unpopulated slots pass through STROBE without a select so that
                        // they complete with the same latency as a zero-delay slot.
                        state_q  <= StStrobe;
                        sel_q    <= cur_ok ? cur_onehot : 4'd0;
                        pod_we_q <= cur_ok && we_q;
                        tcnt_q   <= 8'd0;
                    end else if (!sync_q) begin
                        wcnt_q <= wcnt_q - 8'd1;
                    end
                end
                StStrobe: begin
                    if (!req) begin
                        state_q  <= StIdle;
                        sel_q    <= 4'd0;
                        pod_we_q <= 1'b0;
                    end else if (!cur_ok) begin
                        state_q  <= StAck;
                        wb_ack_q <= 1'b1;
                        if (!we_q) rdat_q <= 16'hFFFF;
                    end else if (ack_ext[slot_q]) begin
                        state_q  <= StAck;
                        wb_ack_q <= 1'b1;
                        sel_q    <= 4'd0;
                        pod_we_q <= 1'b0;
                        if (!we_q) rdat_q <= rdat_slot[slot_q];
                    end else if (tcnt_q == ToLast) begin
                        state_q   <= StAck;
                        wb_ack_q  <= 1'b1;
                        timeout_q <= 1'b1;
                        sel_q     <= 4'd0;
                        pod_we_q  <= 1'b0;
                        if (!we_q) rdat_q <= 16'hFFFF;
                    end else begin
                        tcnt_q <= tcnt_q + 8'd1;
                    end
                end
                StAck: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clkcpu) begin
        if (rst_i) begin
            irq_q  <= 1'b0;
            firq_q <= 1'b0;
        end else begin
            irq_q  <= |(pod_irq & SlotOk[NUM_SLOTS-1:0]);
            firq_q <= |(pod_firq & SlotOk[NUM_SLOTS-1:0]);
        end
    end

    assign wb_dat_o  = rdat_q;
    assign wb_ack    = wb_ack_q;
    assign timeout_o = timeout_q;
    assign pod_sel   = sel_q[NUM_SLOTS-1:0];
    assign pod_we    = pod_we_q;
    assign pod_adr   = pod_adr_q;
    assign pod_wdat  = pod_wdat_q;
    assign irq_o     = irq_q;
    assign firq_o    = firq_q;

endmodule

// File: tb/tb_podule_bus_ctrl.sv
// Randomised bench for podule_bus_ctrl with a cycle-count reference model of each access.
module tb_podule_bus_ctrl;

    localparam int unsigned TO = 255;
    localparam logic [3:0]  MASK = 4'b0001;

    logic        clkcpu = 1'b0;
    logic        rst_i, clk2m_en, wb_cyc, wb_stb, wb_we;
    logic [1:0]  wb_speed;
    logic [13:0] wb_adr;
    logic [15:0] wb_dat_i, wb_dat_o;
    logic        wb_ack, timeout_o;
    logic [3:0]  pod_sel;
    logic        pod_we;
    logic [11:0] pod_adr;
    logic [15:0] pod_wdat;
    logic [63:0] pod_rdat;
    logic [3:0]  pod_ack, pod_irq, pod_firq;
    logic        irq_o, firq_o;

    podule_bus_ctrl dut (
        .clkcpu(clkcpu), .rst_i(rst_i), .clk2m_en(clk2m_en),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_speed(wb_speed),
        .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
        .timeout_o(timeout_o), .pod_sel(pod_sel), .pod_we(pod_we), .pod_adr(pod_adr),
        .pod_wdat(pod_wdat), .pod_rdat(pod_rdat), .pod_ack(pod_ack), .pod_irq(pod_irq),
        .pod_firq(pod_firq), .irq_o(irq_o), .firq_o(firq_o)
    );

    always #5 clkcpu = ~clkcpu;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] model_dat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One access; slot acks in its strobe cycle number dly (0-based), never if dly >= TO.
    task automatic run_txn(input logic [1:0] speed, input logic [1:0] slot, input logic we,
                           input logic [15:0] wdat, input logic [15:0] rval, input int dly,
                           input int en_base);
        logic [11:0] offs;
        logic [15:0] rd [4];
        logic [15:0] exp_dat;
        logic [3:0]  sel_seen;
        int ws, strobe_start, ack_cyc, b, first_sel, sel_cnt, got_ack, bad_q;
        bit ok, to;
        offs = 12'($urandom);
        for (int i = 0; i < 4; i++) rd[i] = 16'($urandom);
        rd[slot] = rval;
        // reference model
        ws = (speed == 2'd0) ? 15 : (speed == 2'd1) ? 7 : (speed == 2'd2) ? 3 : 0;
        if (speed == 2'd3) begin
            b = en_base % 16;
            strobe_start = ((b == 0) ? 16 : 16 - b) + 1;
        end else begin
            strobe_start = ws + 1;
        end
        ok      = MASK[slot];
        to      = ok && (dly >= TO);
        ack_cyc = strobe_start + (!ok ? 1 : to ? TO : dly + 1);
        exp_dat = we ? model_dat : (ok && !to) ? rd[slot] : 16'hFFFF;
        // drive request (cycle 0)
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_speed = speed;
        wb_adr = {slot, offs}; wb_dat_i = wdat;
        pod_rdat = {rd[3], rd[2], rd[1], rd[0]};
        clk2m_en = (en_base % 16 == 0);
        first_sel = -1; sel_cnt = 0; got_ack = -1; bad_q = 0; sel_seen = 4'd0;
        for (int n = 1; n < 700; n++) begin
            @(negedge clkcpu);
            clk2m_en = ((en_base + n) % 16 == 0);
            if (pod_sel != 4'd0) begin
                if (first_sel < 0) first_sel = n;
                sel_cnt++;
                sel_seen |= pod_sel;
                if (pod_we !== we || pod_adr !== offs || pod_wdat !== wdat) bad_q++;
            end
            pod_ack = 4'($urandom);
            pod_ack[slot] = pod_sel[slot] && (sel_cnt - 1 >= dly);
            if (wb_ack === 1'b1) begin
                got_ack = n;
                check("timeout_flag", 32'(timeout_o), 32'(to));
                check("rdata", 32'(wb_dat_o), 32'(exp_dat));
                break;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; pod_ack = 4'd0;
        check("ack_cycle", 32'(got_ack), 32'(ack_cyc));
        check("first_strobe", 32'(first_sel), ok ? 32'(strobe_start) : 32'hFFFF_FFFF);
        check("strobe_len", 32'(sel_cnt), ok ? 32'(ack_cyc - strobe_start) : 32'd0);
        check("strobe_slot", 32'(sel_seen), ok ? 32'(4'b0001 << slot) : 32'd0);
        check("strobe_fields", 32'(bad_q), 32'd0);
        model_dat = exp_dat;
    endtask

    // Drop the strobe at cycle k; nothing may complete or stay selected afterwards.
    task automatic run_abort(input logic [1:0] speed, input int k);
        int hits;
        hits = 0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_speed = speed;
        wb_adr = 14'h0123; pod_ack = 4'd0;
        for (int n = 1; n <= k; n++) begin
            @(negedge clkcpu);
            if (wb_ack) hits++;
        end
        wb_stb = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clkcpu);
            if (wb_ack || timeout_o || pod_sel != 4'd0) hits++;
        end
        wb_cyc = 1'b0;
        check("abort_quiet", 32'(hits), 32'd0);
    endtask

    initial begin
        int r, dly;
        logic [1:0] slot;
        rst_i = 1'b1; clk2m_en = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        wb_speed = 2'd0; wb_adr = 14'd0; wb_dat_i = 16'd0; pod_rdat = 64'd0;
        pod_ack = 4'd0; pod_irq = 4'd0; pod_firq = 4'd0;
        repeat (3) @(negedge clkcpu);
        check("rst_ack", 32'(wb_ack), 32'd0);
        check("rst_timeout", 32'(timeout_o), 32'd0);
        check("rst_sel", 32'(pod_sel), 32'd0);
        check("rst_we", 32'(pod_we), 32'd0);
        check("rst_irq", 32'({irq_o, firq_o}), 32'd0);
        check("rst_data", 32'({wb_dat_o, pod_wdat}), 32'd0);
        check("rst_adr", 32'(pod_adr), 32'd0);
        rst_i = 1'b0;
        model_dat = 16'd0;
        @(negedge clkcpu);

        run_txn(2'd2, 2'd0, 1'b0, 16'h0000, 16'hA55A, 0, 0);   // fast read slot 0
        @(negedge clkcpu);
        run_txn(2'd0, 2'd0, 1'b1, 16'h1234, 16'h0000, 0, 0);   // slow write slot 0
        @(negedge clkcpu);
        run_txn(2'd1, 2'd2, 1'b0, 16'h0000, 16'h5555, 0, 0);   // unpopulated slot 2
        @(negedge clkcpu);
        run_txn(2'd2, 2'd0, 1'b0, 16'h0000, 16'h7777, TO, 0);  // slot never acks
        @(negedge clkcpu);
        run_txn(2'd3, 2'd0, 1'b0, 16'h0000, 16'hBEEF, 1, 5);   // sync speed
        @(negedge clkcpu);
        run_txn(2'd2, 2'd0, 1'b0, 16'h0000, 16'hC3C3, TO - 1, 0); // ack in last strobe cycle
        @(negedge clkcpu);

        for (int t = 0; t < 40; t++) begin
            r    = int'($urandom_range(0, 9));
            dly  = (r == 9) ? TO : r % 4;
            slot = $urandom_range(0, 1) ? 2'd0 : 2'($urandom);
            run_txn(2'($urandom), slot, 1'($urandom), 16'($urandom), 16'($urandom), dly,
                    int'($urandom_range(0, 15)));
            @(negedge clkcpu);
        end

        run_abort(2'd0, 5);     // in WAIT
        run_abort(2'd2, 10);    // in STROBE (slot never acks)
        run_txn(2'd2, 2'd0, 1'b0, 16'h0000, 16'h1111, 2, 0);
        @(negedge clkcpu);

        // reset while strobing
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_speed = 2'd2; wb_adr = 14'h0042;
        pod_ack = 4'd0;
        repeat (6) @(negedge clkcpu);
        check("pre_reset_sel", 32'(pod_sel), 32'd1);
        rst_i = 1'b1;
        @(negedge clkcpu);
        check("reset_sel", 32'(pod_sel), 32'd0);
        check("reset_ack", 32'({wb_ack, timeout_o}), 32'd0);
        rst_i = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        model_dat = 16'd0;
        @(negedge clkcpu);
        run_txn(2'd1, 2'd0, 1'b0, 16'h0000, 16'h2468, 1, 0);
        @(negedge clkcpu);

        // interrupt merge
        pod_irq = 4'b0010; pod_firq = 4'b1110;
        repeat (2) @(negedge clkcpu);
        check("irq_masked", 32'({irq_o, firq_o}), 32'd0);
        pod_irq = 4'b0001;
        @(negedge clkcpu);
        check("irq_set", 32'(irq_o), 32'd1);
        for (int i = 0; i < 12; i++) begin
            logic [3:0] pi, pf;
            pi = 4'($urandom); pf = 4'($urandom);
            pod_irq = pi; pod_firq = pf;
            @(negedge clkcpu);
            check("irq_rand", 32'({irq_o, firq_o}), 32'({|(pi & MASK), |(pf & MASK)}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
